// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_W    = 8;
  localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered storage and a combinational
// read port that always presents the head entry.
module sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
    do_push  = push && (count_q != COUNT_FULL);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are sent
// LSB-first, back to back while the FIFO holds data.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic                   tx,
  output logic                   busy,
  output logic [FIFO_AW:0]       fifo_count
);

  localparam int BIT_W = $clog2(UART_DATA_W);
  localparam logic [15:0]      BAUD_LAST     = 16'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(UART_DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP_BIT = BIT_W'(UART_STOP_BITS - 1);

  uart_state_e            state_q, state_d;
  logic [15:0]            baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [UART_DATA_W-1:0] sh_q, sh_d;
  logic                   tx_q, tx_d;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   fifo_pop, fifo_full, fifo_empty, baud_done;

  sync_fifo #(
    .WIDTH  (UART_DATA_W),
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (valid_in),
    .pop  (fifo_pop),
    .din  (data_in),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    fifo_pop  = 1'b0;
    baud_done = (baud_q == '0);

    // The counter free-runs through every non-idle state, reloading on each bit boundary.
    if (state_q != IDLE) baud_d = baud_done ? BAUD_LAST : baud_q - 16'd1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_dout;
          baud_d   = BAUD_LAST;
          state_d  = START;
        end
      end
      START: begin
        if (baud_done) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          sh_d = sh_q >> 1;
          if (bit_q == LAST_DATA_BIT) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (bit_q != LAST_STOP_BIT) begin
            bit_d = bit_q + BIT_W'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next frame so there is no idle gap.
            fifo_pop = 1'b1;
            sh_d     = fifo_dout;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    if (state_q == START)     tx_d = 1'b0;
    else if (state_q == DATA) tx_d = sh_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign ready_out = !fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-schedule model predicts the
// line, busy, count and ready every cycle; a line decoder recovers bytes.
module tb_uart_tx_fifo;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       ready_out, tx, busy;
  logic [3:0] fifo_count;

  logic       sw_valid = 1'b0;
  logic [7:0] sw_data = '0;
  logic       sw2_ready, sw2_tx, sw2_busy;
  logic [3:0] sw2_count;
  logic       sw434_ready, sw434_tx, sw434_busy;
  logic [3:0] sw434_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.CLK_DIV(2), .FIFO_AW(3)) dut_div2 (
    .clk(clk), .rst(rst), .data_in(sw_data), .valid_in(sw_valid),
    .ready_out(sw2_ready), .tx(sw2_tx), .busy(sw2_busy), .fifo_count(sw2_count)
  );

  uart_tx_fifo #(.CLK_DIV(434), .FIFO_AW(3)) dut_div434 (
    .clk(clk), .rst(rst), .data_in(sw_data), .valid_in(sw_valid),
    .ready_out(sw434_ready), .tx(sw434_tx), .busy(sw434_busy), .fifo_count(sw434_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each accepted byte is assigned the edge at which its frame
  // starts (popped); the line and status follow from those start edges alone.
  typedef struct {
    logic [7:0] d;
    int         p;
  } frame_t;

  frame_t     mq[$];
  logic [7:0] sent_q[$];
  int         cyc = 0;
  int         last_p = -FRAME;
  logic       m_ready = 1'b1;
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  int         m_count = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic model_eval();
    m_tx    = 1'b1;
    m_busy  = 1'b0;
    m_count = 0;
    foreach (mq[i]) begin
      if (mq[i].p > cyc) m_count++;
      if (cyc < mq[i].p + FRAME) m_busy = 1'b1;
      if (cyc >= mq[i].p + 1 && cyc <= mq[i].p + FRAME)
        m_tx = frame_bit(mq[i].d, (cyc - mq[i].p - 1) / DIV);
    end
    m_ready = (m_count != DEPTH);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      sent_q.delete();
      cyc     = 0;
      last_p  = -FRAME;
      m_ready = 1'b1;
    end else begin
      cyc++;
      if (valid_in === 1'b1 && m_ready) begin
        int p;
        p = (cyc + 1 > last_p + FRAME) ? cyc + 1 : last_p + FRAME;
        mq.push_back('{d: data_in, p: p});
        sent_q.push_back(data_in);
        last_p = p;
      end
      while (mq.size() > 0 && mq[0].p + FRAME < cyc) void'(mq.pop_front());
      model_eval();
      #1;
      if (!rst) begin
        check("tx", tx, m_tx);
        check("busy", busy, m_busy);
        check("fifo_count", fifo_count, m_count);
        check("ready_out", ready_out, m_ready);
      end
    end
  end

  // Line decoder for the main instance, sampling mid-bit on the falling clock edge.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte = '0;
  bit         rx_on = 1'b0;
  int         rx_ph = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_ph = 0;
      end
    end else begin
      rx_ph++;
      if (rx_ph >= DIV && rx_ph < 9 * DIV && (rx_ph % DIV) == DIV / 2)
        rx_byte[rx_ph / DIV - 1] = tx;
      if (rx_ph == 9 * DIV + DIV / 2 && tx === 1'b1) rx_q.push_back(rx_byte);
      if (rx_ph == FRAME - 1) rx_on = 1'b0;
    end
  end

  task automatic check_decoded(input string tag);
    check({tag, "_rx_n"}, rx_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_rx%0d", tag, i), rx_q[i], sent_q[i]);
    rx_q.delete();
    sent_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int limit, output int at);
    int i;
    i = 0;
    do begin
      @(posedge clk);
      #2;
      i++;
    end while (busy !== 1'b0 && i < limit);
    check({tag, "_drained"}, busy, 1'b0);
    at = cyc;
  endtask

  task automatic run_sweep();
    int hit2[11];
    int hit434[11];
    int span;
    int s;
    span = 10 * 434 + 4;
    foreach (hit2[i]) begin
      hit2[i]   = 0;
      hit434[i] = 0;
    end
    @(negedge clk);
    sw_valid = 1'b1;
    sw_data  = 8'h80;
    @(negedge clk);
    sw_valid = 1'b0;
    sw_data  = 'x;
    for (int j = 1; j <= span; j++) begin
      @(posedge clk);
      #1;
      s = (j >= 2 && j <= 1 + 20) ? (j - 2) / 2 : 10;
      if (sw2_tx === frame_bit(8'h80, s)) hit2[s]++;
      s = (j >= 2 && j <= 1 + 4340) ? (j - 2) / 434 : 10;
      if (sw434_tx === frame_bit(8'h80, s)) hit434[s]++;
    end
    for (int k = 0; k < 10; k++) begin
      check($sformatf("div2_bit%0d_len", k), hit2[k], 2);
      check($sformatf("div434_bit%0d_len", k), hit434[k], 434);
    end
    check("div2_idle_high", hit2[10], span - 20);
    check("div434_idle_high", hit434[10], span - 4340);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, at, idx, guard;
    bit  found, seen_full, will;

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 4'd0);
    check("rst_ready", ready_out, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte 0x55: start bit two edges after the push edge.
    valid_in = 1'b1;
    data_in  = 8'h55;
    @(posedge clk);
    #2;
    n = cyc;
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 'x;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #2;
      if (tx === 1'b0) begin
        found = 1'b1;
        check("single_start_latency", cyc - n, 2);
      end
    end
    check("single_start_seen", found, 1'b1);
    wait_idle("single", 100, at);
    check("single_busy_fall", at - n, 41);
    repeat (4) @(negedge clk);
    check_decoded("single");

    // Back-to-back 0xA3, 0x0F.
    valid_in = 1'b1;
    data_in  = 8'hA3;
    @(negedge clk);
    data_in = 8'h0F;
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 'x;
    wait_idle("b2b", 200, at);
    repeat (4) @(negedge clk);
    check_decoded("b2b");

    // FIFO full: hold valid and offer 0x00..0x09 while the line drains.
    idx       = 0;
    guard     = 0;
    seen_full = 1'b0;
    while (idx < 10 && guard < 1000) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = 8'(idx);
      if (fifo_count == 4'd8) begin
        seen_full = 1'b1;
        check("full_ready_low", ready_out, 1'b0);
      end
      will = ready_out;
      @(posedge clk);
      if (will) idx++;
      guard++;
    end
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 'x;
    check("full_seen", seen_full, 1'b1);
    check("full_all_pushed", idx, 10);
    wait_idle("full", 1000, at);
    repeat (4) @(negedge clk);
    check("full_rx_total", rx_q.size(), 10);
    for (int i = 0; i < 10 && i < rx_q.size(); i++)
      check($sformatf("full_order%0d", i), rx_q[i], i);
    check_decoded("full");

    // Randomised traffic, including X on data_in while valid is low.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        valid_in = 1'b1;
        data_in  = 8'($urandom);
      end else begin
        valid_in = 1'b0;
        data_in  = 'x;
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 'x;
    wait_idle("random", 1000, at);
    repeat (4) @(negedge clk);
    check_decoded("random");

    // Reset mid-frame during data bit 3 of the first byte.
    valid_in = 1'b1;
    data_in  = 8'hFF;
    @(posedge clk);
    #2;
    n = cyc;
    @(negedge clk);
    data_in = 8'h12;
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 'x;
    guard = 0;
    while (cyc < n + 19 && guard < 100) begin
      @(posedge clk);
      #2;
      guard++;
    end
    check("midrst_reached_bit3", cyc, n + 19);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", fifo_count, 4'd0);
    check("midrst_ready", ready_out, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("midrst_count_after", fifo_count, 4'd0);
    check_decoded("midrst");

    // Parameter sweep on the CLK_DIV=2 and CLK_DIV=434 instances.
    run_sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
